// File: rtl/snr_cal_controller_if.sv
// snr_cal_controller_if
//   Groups the control, sample and status signals exchanged between the
//   SNR calibration controller and its host/datapath.
//   master : host/datapath side (drives start, recal, sample/SNR strobes)
//   slave  : controller side (drives quiet_period, calibrated,
//            signal_present, state)
//   start          host -> ctl  request first calibration from IDLE
//   recal          host -> ctl  request recalibration from any non-IDLE state
//   sample_valid   dp   -> ctl  one accepted audio sample this cycle
//   snr_db         dp   -> ctl  signed Q8.8 SNR estimate
//   snr_valid      dp   -> ctl  snr_db valid this cycle
//   quiet_period   ctl  -> dp   noise-calibration enable
//   calibrated     ctl  -> host noise estimate complete and settled
//   signal_present ctl  -> host hysteresis-qualified detection flag
//   state          ctl  -> host IDLE=0, CAL=1, SETTLE=2, RUN=3
interface snr_cal_controller_if #(
    parameter int unsigned SNR_WIDTH = 16
);
    logic                        start;
    logic                        recal;
    logic                        sample_valid;
    logic signed [SNR_WIDTH-1:0] snr_db;
    logic                        snr_valid;
    logic                        quiet_period;
    logic                        calibrated;
    logic                        signal_present;
    logic [1:0]                  state;

    modport master (
        output start, recal, sample_valid, snr_db, snr_valid,
        input  quiet_period, calibrated, signal_present, state
    );

    modport slave (
        input  start, recal, sample_valid, snr_db, snr_valid,
        output quiet_period, calibrated, signal_present, state
    );
endinterface

// File: rtl/snr_cal_controller.sv
// snr_cal_controller
//   Sequences noise calibration (CAL), a settling interval (SETTLE) and
//   normal operation (RUN) for an SNR datapath, and qualifies the SNR
//   estimate in RUN into a hysteresis-filtered signal_present flag.
//   clk_i   : sole clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : snr_cal_controller_if.slave (see interface header)
module snr_cal_controller #(
    parameter int unsigned                 SNR_WIDTH      = 16,
    parameter int unsigned                 CAL_SAMPLES    = 4096,
    parameter int unsigned                 SETTLE_SAMPLES = 64,
    parameter int unsigned                 HOLD_SAMPLES   = 16,
    parameter logic signed [SNR_WIDTH-1:0] SNR_ON         = 16'sd2560,
    parameter logic signed [SNR_WIDTH-1:0] SNR_OFF        = 16'sd1536
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    snr_cal_controller_if.slave  bus
);

    localparam int unsigned MAX_AB = (CAL_SAMPLES > SETTLE_SAMPLES) ? CAL_SAMPLES : SETTLE_SAMPLES;
    localparam int unsigned MAX_P  = (MAX_AB > HOLD_SAMPLES) ? MAX_AB : HOLD_SAMPLES;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;

    // Counter value on the edge that completes each phase.
    localparam logic [CW-1:0] CAL_LAST    = CW'((CAL_SAMPLES    > 0) ? CAL_SAMPLES    - 1 : 0);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST   = CW'((HOLD_SAMPLES   > 0) ? HOLD_SAMPLES   - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CAL    = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               hold_q, hold_d;
    logic                        sp_q, sp_d;
    logic                        cal_q, cal_d;
    logic signed [SNR_WIDTH-1:0] snr_s;
    logic                        qualify;

    assign snr_s = bus.snr_db;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            sp_q    <= 1'b0;
            cal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sp_q    <= sp_d;
            cal_q   <= cal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sp_d    = sp_q;
        // While asserted, look for a sample below OFF; while clear, for one at/above ON.
        qualify = sp_q ? (snr_s < SNR_OFF) : (snr_s >= SNR_ON);

        if (state_q != S_IDLE && bus.recal) begin
            state_d = S_CAL;
            cnt_d   = '0;
            hold_d  = '0;
            sp_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start || bus.recal) begin
                        state_d = S_CAL;
                        cnt_d   = '0;
                    end
                end
                S_CAL: begin
                    if (bus.sample_valid) begin
                        if (cnt_q >= CAL_LAST) begin
                            // A zero-length settle skips straight to RUN.
                            state_d = (SETTLE_SAMPLES == 0) ? S_RUN : S_SETTLE;
                            cnt_d   = '0;
                            hold_d  = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                S_SETTLE: begin
                    if (bus.sample_valid) begin
                        if (cnt_q >= SETTLE_LAST) begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            hold_d  = '0;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                S_RUN: begin
                    if (bus.snr_valid) begin
                        if (!qualify) begin
                            hold_d = '0;
                        end else if (hold_q >= HOLD_LAST) begin
                            sp_d   = ~sp_q;
                            hold_d = '0;
                        end else begin
                            hold_d = sat_inc(hold_q);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        cal_d = (state_d == S_RUN);
    end

    assign bus.quiet_period   = (state_q == S_CAL);
    assign bus.calibrated     = cal_q;
    assign bus.signal_present = sp_q;
    assign bus.state          = state_q;

endmodule

// File: doc/snr_cal_controller.md
SNR_CAL_CONTROLLER -- requirements
Module: snr_cal_controller

Interface
REQ-001 Parameter SNR_WIDTH, default 16, is the snr_db width (signed, Q8.8 dB).
REQ-002 Parameter CAL_SAMPLES, default 4096, is the number of quiet samples per noise calibration.
REQ-003 Parameter SETTLE_SAMPLES, default 64, is the number of samples to wait after calibration before SNR is trusted.
REQ-004 Parameter HOLD_SAMPLES, default 16, is the number of consecutive snr samples needed to change signal_present.
REQ-005 Parameter SNR_ON, default 16'sd2560 (10 dB), is the signed Q8.8 assert threshold.
REQ-006 Parameter SNR_OFF, default 16'sd1536 (6 dB), is the signed Q8.8 deassert threshold; SNR_OFF <= SNR_ON.
REQ-007 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-008 reset  input  1  Asynchronous, active-high reset.
REQ-009 start  input  1  Level/pulse that requests the first calibration from IDLE.
REQ-010 recal  input  1  Requests recalibration from any non-IDLE state.
REQ-011 sample_valid  input  1  One accepted audio sample at the SNR datapath this cycle.
REQ-012 snr_db  input  SNR_WIDTH  Signed SNR estimate from the datapath.
REQ-013 snr_valid  input  1  snr_db is valid this cycle.
REQ-014 quiet_period  output  1  Drives datapath noise-calibration enable.
REQ-015 calibrated  output  1  Noise estimate is complete and settled.
REQ-016 signal_present  output  1  Hysteresis-qualified SNR detection flag.
REQ-017 state  output  2  Current state encoding: IDLE=0, CAL=1, SETTLE=2, RUN=3.

Function
REQ-018 The FSM SHALL have states IDLE, CAL, SETTLE, RUN with a single sample counter cleared on every state entry.
REQ-019 IDLE SHALL go to CAL on the cycle start=1 or recal=1.
REQ-020 CAL SHALL assert quiet_period combinationally from state (high in CAL only) and count sample_valid cycles.
REQ-021 CAL SHALL go to SETTLE on the edge where the counter reaches CAL_SAMPLES-1 and sample_valid=1, i.e. exactly CAL_SAMPLES samples are seen with quiet_period=1.
REQ-022 SETTLE SHALL count sample_valid cycles and go to RUN after SETTLE_SAMPLES samples; SETTLE_SAMPLES=0 SHALL go directly CAL->RUN.
REQ-023 calibrated SHALL be registered, set on entry to RUN, and cleared on entry to CAL or IDLE.
REQ-024 In RUN, the block SHALL count consecutive snr_valid samples with snr_db >= SNR_ON (signed compare) while signal_present=0, and set signal_present when the count reaches HOLD_SAMPLES.
REQ-025 In RUN, the block SHALL count consecutive snr_valid samples with snr_db < SNR_OFF while signal_present=1, and clear signal_present when the count reaches HOLD_SAMPLES.
REQ-026 A qualifying-sample run SHALL restart at zero on any non-qualifying snr_valid sample; cycles with snr_valid=0 SHALL leave the counter unchanged.
REQ-027 snr_db between SNR_OFF and SNR_ON SHALL leave signal_present unchanged.
REQ-028 recal=1 in CAL, SETTLE or RUN SHALL force CAL next cycle, restart the counter, and clear signal_present and calibrated; recal has priority over all other transitions.
REQ-029 start while not IDLE SHALL be ignored.
REQ-030 Counters SHALL saturate and never wrap; widths are $clog2 of the largest parameter plus 1.
REQ-031 snr_db and snr_valid SHALL be ignored outside RUN.

Reset
REQ-032 While reset=1, the block SHALL be in IDLE with quiet_period=0, calibrated=0, signal_present=0, state=0, and all counters at 0, regardless of clk.
REQ-033 Reset asserted mid-CAL SHALL drop quiet_period asynchronously; after release the block SHALL remain in IDLE until start.

Verification
REQ-034 With CAL_SAMPLES=8 and SETTLE_SAMPLES=4: start pulse, then sample_valid every 2nd cycle -> quiet_period high for exactly 8 samples, state sequence 1,2,3, and calibrated=1 after the 12th sample.
REQ-035 With HOLD_SAMPLES=4 in RUN: snr_db=2560 x3, 2559 x1, 2560 x4 -> signal_present rises only after the 8th sample.
REQ-036 With signal_present=1: snr_db=2000 x10 -> no change; snr_db=1535 x4 -> cleared after the 4th sample.
REQ-037 In RUN with signal_present=1: pulse recal -> next cycle state=1, quiet_period=1, calibrated=0, signal_present=0.
REQ-038 Assert reset asynchronously at CAL sample 5 -> outputs zero before the next clk edge; start after release -> full 8-sample calibration.
REQ-039 In SETTLE: snr_valid with snr_db=0x7FFF -> signal_present stays 0; start=1 in RUN -> no state change.
